// File: rtl/regfile_onehot_wr_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_onehot_wr_if
// Brief    : Write/read bus of the MIPS register file (one-hot write select).
// Revision : 1.0
// ============================================================================
interface regfile_onehot_wr_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
);
  logic                we;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rs_addr;
  logic [ADDR_W-1:0]   rt_addr;
  logic [DATA_W-1:0]   rs_data;
  logic [DATA_W-1:0]   rt_data;
  logic                sel_err;
  logic [15:0]         wr_count;

  modport master (
    output we, wr_sel, wr_data, rs_addr, rt_addr,
    input  rs_data, rt_data, sel_err, wr_count
  );

  modport slave (
    input  we, wr_sel, wr_data, rs_addr, rt_addr,
    output rs_data, rt_data, sel_err, wr_count
  );
endinterface
`default_nettype wire

// File: rtl/regfile_onehot_wr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_onehot_wr
// Brief    : 32x32 MIPS register file, async reads, one-hot synchronous write.
//            Optional macro REGFILE_BYPASS_EN adds write-through forwarding.
// Revision : 1.0
// ============================================================================
module regfile_onehot_wr #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_onehot_wr_if.slave   bus
);

  localparam logic [NUM_REGS-1:0] c_one     = NUM_REGS'(1);
  localparam logic [15:0]         c_cnt_max = 16'hFFFF;

  logic              w_onehot;
  logic              w_legal;
  logic              w_commit;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic              r_sel_err;
  logic [15:0]       r_wr_count;
  logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
  assign w_onehot = (|bus.wr_sel) & ~(|(bus.wr_sel & (bus.wr_sel - c_one)));
  assign w_legal  = bus.we & w_onehot;
  assign w_commit = w_legal & ~bus.wr_sel[0];

  generate
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_regs[i] <= '0;
        end else if (w_commit && bus.wr_sel[i]) begin
          r_regs[i] <= bus.wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (bus.we && !w_onehot) begin
      r_sel_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= '0;
    end else if (w_commit && (r_wr_count != c_cnt_max)) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) v = r_regs[i];
    end
    return v;
  endfunction

  // w_commit already excludes $0, so forwarding can never expose a $0 write.
  always_comb begin
    w_rs_data = f_read(bus.rs_addr);
    w_rt_data = f_read(bus.rt_addr);
`ifdef REGFILE_BYPASS_EN
    if (w_commit && bus.wr_sel[bus.rs_addr]) w_rs_data = bus.wr_data;
    if (w_commit && bus.wr_sel[bus.rt_addr]) w_rt_data = bus.wr_data;
`else
    w_rs_data = w_rs_data;
    w_rt_data = w_rt_data;
`endif
    if (reset) begin
      w_rs_data = '0;
      w_rt_data = '0;
    end
  end

  assign bus.rs_data  = w_rs_data;
  assign bus.rt_data  = w_rt_data;
  assign bus.sel_err  = r_sel_err;
  assign bus.wr_count = r_wr_count;

endmodule
`default_nettype wire
